// File: rtl/amba_host_master.sv
// amba_host_master
// Host-side initiator for the BSG register-access bus. Accepts one command
// at a time, drives a valid/ready transfer toward the register slave, and
// returns a single-cycle response carrying read data or a timeout error.
// After every transfer the bus request is held low for one GAP cycle so the
// slave always sees a falling edge of `valid` between transfers.

module amba_host_master #(
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  SYS_CLK,
  input  logic                  rst,
  // host command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // host response side
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  // bus side toward the register slave
  output logic                  valid,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] amba_data_in
);

  // Wait counter only needs to reach TIMEOUT-1; keep at least one bit.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state_r;
  state_t                  next_state_s;
  logic                    accept_s;
  logic                    complete_s;
  logic                    abort_s;
  logic [CNT_W-1:0]        cnt_r;
  logic                    valid_r;
  logic                    write_r;
  logic [DATA_WIDTH-1:0]   addr_r;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    rsp_valid_r;
  logic [DATA_WIDTH-1:0]   rsp_rdata_r;
  logic                    rsp_err_r;

  // State register; reset always returns to IDLE and drops any transfer.
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode plus the accept / complete / abort event strobes.
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    complete_s   = 1'b0;
    abort_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          accept_s     = 1'b1;
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        // ready wins over timeout when both hit on the same edge
        if (ready) begin
          complete_s   = 1'b1;
          next_state_s = GAP;
        end else if (cnt_r == CNT_LAST) begin
          abort_s      = 1'b1;
          next_state_s = GAP;
        end else begin
          next_state_s = REQ;
        end
      end
      GAP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Bus request registers and wait counter; bus fields change only on accept.
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      write_r <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
      cnt_r   <= '0;
    end else if (accept_s) begin
      valid_r <= 1'b1;
      write_r <= cmd_write;
      addr_r  <= cmd_addr;
      data_r  <= cmd_wdata;
      cnt_r   <= '0;
    end else if (complete_s || abort_s) begin
      valid_r <= 1'b0;
    end else if (state_r == REQ) begin
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

  // Response registers: one-cycle strobe, payload held until the next response.
  always_ff @(posedge SYS_CLK or negedge rst) begin
    if (!rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= complete_s | abort_s;
      if (complete_s) begin
        rsp_err_r   <= 1'b0;
        rsp_rdata_r <= write_r ? '0 : amba_data_in;
      end else if (abort_s) begin
        rsp_err_r   <= 1'b1;
        rsp_rdata_r <= '0;
      end
    end
  end

  // cmd_ready is gated by reset so it reads 0 while reset is asserted.
  assign cmd_ready = (state_r == IDLE) && rst;
  assign busy      = (state_r != IDLE);
  assign valid     = valid_r;
  assign write     = write_r;
  assign addr_out  = addr_r;
  assign data_out  = data_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_amba_host_master.sv
// tb_amba_host_master
// Self-checking bench: each transfer's outcome (completion edge, error flag,
// read data) is predicted from the wait count alone and compared against the
// DUT pins sampled on the falling clock edge.

module tb_amba_host_master;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          SYS_CLK = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [DW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic          valid;
  logic          write;
  logic [DW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          ready;
  logic [DW-1:0] amba_data_in;

  int checks   = 0;
  int errors   = 0;
  int rsp_seen = 0;
  int rsp_exp  = 0;

  amba_host_master #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .SYS_CLK      (SYS_CLK),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .valid        (valid),
    .write        (write),
    .addr_out     (addr_out),
    .data_out     (data_out),
    .ready        (ready),
    .amba_data_in (amba_data_in)
  );

  // free-running clock
  always #5 SYS_CLK = ~SYS_CLK;

  // count every cycle in which a response strobe is seen
  always @(negedge SYS_CLK) begin
    if (rsp_valid === 1'b1) rsp_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One command with `w` wait cycles before ready (w >= TO means never ready).
  task automatic run_txn(input logic wr, input logic [DW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rd, input int w);
    int      k;
    bit      done;
    logic    exp_err;
    int      exp_k;
    logic [DW-1:0] exp_rdata;
    exp_err   = (w >= TO);
    exp_k     = exp_err ? TO : w + 1;
    exp_rdata = (exp_err || wr) ? 8'h00 : rd;

    k = 0;
    @(negedge SYS_CLK);
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge SYS_CLK);
      k++;
    end
    check_eq("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    cmd_valid    = 1'b1;
    cmd_write    = wr;
    cmd_addr     = a;
    cmd_wdata    = wd;
    ready        = 1'b0;
    amba_data_in = 8'($urandom);
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    check_eq("acc_valid", 32'(valid), 32'd1);
    check_eq("acc_write", 32'(write), 32'(wr));
    check_eq("acc_addr", 32'(addr_out), 32'(a));
    check_eq("acc_data", 32'(data_out), 32'(wd));
    check_eq("acc_busy", 32'(busy), 32'd1);
    check_eq("acc_cmd_ready", 32'(cmd_ready), 32'd0);

    // commands offered while busy must be ignored
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);

    done = 1'b0;
    k    = 0;
    while (!done && k < TO + 4) begin
      k++;
      ready        = (k > w);
      amba_data_in = (k > w) ? rd : 8'($urandom);
      @(posedge SYS_CLK);
      @(negedge SYS_CLK);
      if (rsp_valid === 1'b1) begin
        done = 1'b1;
      end else begin
        check_eq("req_valid", 32'(valid), 32'd1);
        check_eq("req_addr_stable", 32'(addr_out), 32'(a));
        check_eq("req_write_stable", 32'(write), 32'(wr));
        check_eq("req_data_stable", 32'(data_out), 32'(wd));
      end
    end
    check_eq("rsp_arrived", 32'(done), 32'd1);
    if (done) rsp_exp++;
    check_eq("complete_edge", 32'(k), 32'(exp_k));
    check_eq("rsp_err", 32'(rsp_err), 32'(exp_err));
    check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
    check_eq("gap_valid", 32'(valid), 32'd0);
    check_eq("gap_busy", 32'(busy), 32'd1);
    check_eq("gap_cmd_ready", 32'(cmd_ready), 32'd0);

    cmd_valid    = 1'b0;
    ready        = 1'($urandom_range(0, 1));
    amba_data_in = 8'($urandom);
    @(negedge SYS_CLK);
    check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_valid", 32'(valid), 32'd0);
    check_eq("post_addr_held", 32'(addr_out), 32'(a));
    check_eq("post_write_held", 32'(write), 32'(wr));
    check_eq("post_data_held", 32'(data_out), 32'(wd));
    check_eq("post_err_held", 32'(rsp_err), 32'(exp_err));
    check_eq("post_rdata_held", 32'(rsp_rdata), 32'(exp_rdata));
    ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    cmd_valid    = 1'b0;
    cmd_write    = 1'b0;
    cmd_addr     = 8'h00;
    cmd_wdata    = 8'h00;
    ready        = 1'b0;
    amba_data_in = 8'h00;

    repeat (2) @(negedge SYS_CLK);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_write", 32'(write), 32'd0);
    check_eq("rst_addr", 32'(addr_out), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    @(negedge SYS_CLK);
    check_eq("rel_cmd_ready", 32'(cmd_ready), 32'd1);

    // directed cases
    run_txn(1'b1, 8'h10, 8'hA5, 8'h00, 0);
    run_txn(1'b0, 8'h11, 8'h00, 8'h3C, 3);
    run_txn(1'b1, 8'h12, 8'h5A, 8'h00, 100);
    run_txn(1'b0, 8'h11, 8'h00, 8'h77, TO - 1);
    run_txn(1'b0, 8'h12, 8'h00, 8'h88, TO);

    // randomized transfers
    for (int i = 0; i < 25; i++) begin
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, TO + 3)));
    end

    // cmd_valid held high across two commands
    @(negedge SYS_CLK);
    cmd_valid    = 1'b1;
    cmd_write    = 1'b0;
    cmd_addr     = 8'h11;
    cmd_wdata    = 8'h00;
    ready        = 1'b1;
    amba_data_in = 8'hC3;
    @(posedge SYS_CLK); @(negedge SYS_CLK);
    check_eq("b2b_a_valid", 32'(valid), 32'd1);
    check_eq("b2b_a_addr", 32'(addr_out), 32'h11);
    cmd_write = 1'b1;
    cmd_addr  = 8'h12;
    cmd_wdata = 8'h99;
    @(posedge SYS_CLK); @(negedge SYS_CLK);
    check_eq("b2b_a_rsp", 32'(rsp_valid), 32'd1);
    check_eq("b2b_a_rdata", 32'(rsp_rdata), 32'hC3);
    check_eq("b2b_a_done_valid", 32'(valid), 32'd0);
    rsp_exp++;
    @(posedge SYS_CLK); @(negedge SYS_CLK);
    check_eq("b2b_gap_valid", 32'(valid), 32'd0);
    check_eq("b2b_gap_rsp", 32'(rsp_valid), 32'd0);
    check_eq("b2b_idle_ready", 32'(cmd_ready), 32'd1);
    @(posedge SYS_CLK); @(negedge SYS_CLK);
    check_eq("b2b_b_valid", 32'(valid), 32'd1);
    check_eq("b2b_b_addr", 32'(addr_out), 32'h12);
    check_eq("b2b_b_write", 32'(write), 32'd1);
    check_eq("b2b_b_data", 32'(data_out), 32'h99);
    check_eq("b2b_b_no_rsp", 32'(rsp_valid), 32'd0);
    cmd_valid = 1'b0;
    @(posedge SYS_CLK); @(negedge SYS_CLK);
    check_eq("b2b_b_rsp", 32'(rsp_valid), 32'd1);
    check_eq("b2b_b_rdata", 32'(rsp_rdata), 32'h00);
    check_eq("b2b_b_err", 32'(rsp_err), 32'd0);
    rsp_exp++;
    ready = 1'b0;
    @(negedge SYS_CLK);

    // reset asserted while a request is outstanding
    @(negedge SYS_CLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h10;
    ready     = 1'b0;
    @(posedge SYS_CLK); @(negedge SYS_CLK);
    check_eq("mid_valid", 32'(valid), 32'd1);
    cmd_valid = 1'b0;
    @(posedge SYS_CLK); @(negedge SYS_CLK);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_addr", 32'(addr_out), 32'd0);
    check_eq("mid_rst_write", 32'(write), 32'd0);
    check_eq("mid_rst_data", 32'(data_out), 32'd0);
    check_eq("mid_rst_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("mid_rst_err", 32'(rsp_err), 32'd0);
    ready = 1'b1;
    @(negedge SYS_CLK);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge SYS_CLK);
      check_eq("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    check_eq("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    ready = 1'b0;
    run_txn(1'b0, 8'h10, 8'h00, 8'h5E, 2);

    repeat (2) @(negedge SYS_CLK);
    check_eq("rsp_pulse_count", 32'(rsp_seen), 32'(rsp_exp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
